// File: rtl/sevenseg_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scan controller.
// Segment vectors are active low, ordered {CA,CB,CC,CD,CE,CF,CG} with CA as MSB.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t hex2seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    return 7'b0000001;
      4'h1:    return 7'b1001111;
      4'h2:    return 7'b0010010;
      4'h3:    return 7'b0000110;
      4'h4:    return 7'b1001100;
      4'h5:    return 7'b0100100;
      4'h6:    return 7'b0100000;
      4'h7:    return 7'b0001111;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0000100;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b1100000;
      4'hC:    return 7'b0110001;
      4'hD:    return 7'b1000010;
      4'hE:    return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational nibble-to-segment decoder; one instance serves the active scan slot.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  assign o_seg = hex2seg(i_nibble);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment driver with per-digit hex/raw mode, enables, decimal
// points, PWM dimming and a double buffer that only commits at frame boundaries.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_W      = 17,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [7*NUM_DIGITS-1:0] i_raw_segs,
  input  logic [NUM_DIGITS-1:0]   i_raw_mode,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic [BRIGHT_W-1:0]     i_brightness,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [7*NUM_DIGITS-1:0] raw_segs;
    logic [NUM_DIGITS-1:0]   raw_mode;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [BRIGHT_W-1:0]     brightness;
  } frame_t;

  localparam frame_t FRAME_RST = '{digits: '0, raw_segs: '0, raw_mode: '0, dp: '0,
                                   digit_en: '0, brightness: '1};

  logic [DIV_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  frame_t                r_pend;
  frame_t                r_shadow;
  logic                  r_pend_vld;
  logic [NUM_DIGITS-1:0] r_an;
  seg_t                  r_seg;
  logic                  r_dp;
  logic                  r_frame_done;

  frame_t                w_in;
  logic                  w_tick;
  logic                  w_boundary;
  logic [3:0]            w_nibble;
  seg_t                  w_hex_seg;
  seg_t                  w_seg;
  logic                  w_on;
  logic [NUM_DIGITS-1:0] w_an_sel;

  assign w_in = '{digits: i_digits, raw_segs: i_raw_segs, raw_mode: i_raw_mode, dp: i_dp,
                  digit_en: i_digit_en, brightness: i_brightness};

  assign w_tick     = &r_cnt;
  assign w_boundary = w_tick && (r_idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_tick) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // NOTE: the data buffers are reset as well, because a reset must blank the display, not just stop the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= FRAME_RST;
      r_shadow   <= FRAME_RST;
      r_pend_vld <= 1'b0;
    end else if (w_boundary && i_load) begin
      r_shadow   <= w_in;
      r_pend_vld <= 1'b0;
    end else if (w_boundary && r_pend_vld) begin
      r_shadow   <= r_pend;
      r_pend_vld <= 1'b0;
    end else if (i_load) begin
      r_pend     <= w_in;
      r_pend_vld <= 1'b1;
    end
  end

  assign w_nibble = r_shadow.digits[4*r_idx +: 4];

  sevenseg_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_hex_seg)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_an_sel        = '1;
    w_an_sel[r_idx] = 1'b0;
    w_seg           = r_shadow.raw_mode[r_idx] ? r_shadow.raw_segs[7*r_idx +: 7] : w_hex_seg;
    w_on            = r_shadow.digit_en[r_idx] &&
                      (r_cnt[DIV_W-1 -: BRIGHT_W] <= r_shadow.brightness);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (w_on) begin
        r_an  <= w_an_sel;
        r_seg <= w_seg;
        r_dp  <= ~r_shadow.dp[r_idx];
      end else begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end
    end
  end

  assign o_an         = r_an;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: a full-brightness-resolution instance and a 2-bit dimming
// instance share stimulus; a time-arithmetic reference model predicts every output cycle.
module tb_sevenseg_scan_ctrl;

  localparam int N     = 8;
  localparam int SLOT  = 16;
  localparam int FRAME = N * SLOT;

  typedef struct packed {
    logic [31:0] digits;
    logic [55:0] raw;
    logic [7:0]  raw_mode;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic [3:0]  b4;
    logic [1:0]  b2;
  } frame_t;

  localparam frame_t FRAME_RST = '{digits: '0, raw: '0, raw_mode: '0, dp: '0, en: '0,
                                   b4: 4'hF, b2: 2'h3};

  logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] digits = '0;
  logic [55:0] raw = '0;
  logic [7:0]  raw_mode = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  en = '0;
  logic [3:0]  b4 = '0;
  logic [1:0]  b2 = '0;

  logic [7:0] o_an, o_an2;
  logic [6:0] o_seg, o_seg2;
  logic       o_dp, o_dp2, o_fd, o_fd2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .DIV_W(4), .BRIGHT_W(4)) u_dut (
    .clk(clk), .rst(rst), .i_load(load), .i_digits(digits), .i_raw_segs(raw),
    .i_raw_mode(raw_mode), .i_dp(dp), .i_digit_en(en), .i_brightness(b4),
    .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp), .o_frame_done(o_fd)
  );

  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .DIV_W(4), .BRIGHT_W(2)) u_dut_dim (
    .clk(clk), .rst(rst), .i_load(load), .i_digits(digits), .i_raw_segs(raw),
    .i_raw_mode(raw_mode), .i_dp(dp), .i_digit_en(en), .i_brightness(b2),
    .o_an(o_an2), .o_seg(o_seg2), .o_dp(o_dp2), .o_frame_done(o_fd2)
  );

  // Reference model: position in the scan is derived from elapsed cycles since reset.
  frame_t     m_sh, m_pend;
  bit         m_pend_vld;
  int         m_t;
  logic [7:0] exp_an, exp_an2;
  logic [6:0] exp_seg, exp_seg2;
  logic       exp_dp, exp_dp2, exp_fd;

  always @(posedge clk) begin : ref_model
    int         slot, phase;
    bit         eof, on4, on2;
    logic [6:0] seg;
    frame_t     f_in;
    f_in = '{digits: digits, raw: raw, raw_mode: raw_mode, dp: dp, en: en, b4: b4, b2: b2};
    if (rst) begin
      m_t <= 0; m_sh <= FRAME_RST; m_pend <= FRAME_RST; m_pend_vld <= 1'b0;
      exp_an <= 8'hFF; exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_fd <= 1'b0;
      exp_an2 <= 8'hFF; exp_seg2 <= 7'h7F; exp_dp2 <= 1'b1;
    end else begin
      slot  = (m_t / SLOT) % N;
      phase = m_t % SLOT;
      eof   = (m_t % FRAME) == FRAME - 1;
      seg   = m_sh.raw_mode[slot] ? m_sh.raw[7*slot +: 7] : hex_tab[m_sh.digits[4*slot +: 4]];
      on4   = m_sh.en[slot] && (phase < (int'(m_sh.b4) + 1) * (SLOT / 16));
      on2   = m_sh.en[slot] && (phase < (int'(m_sh.b2) + 1) * (SLOT / 4));
      exp_an   <= on4 ? ~(8'd1 << slot) : 8'hFF;
      exp_seg  <= on4 ? seg : 7'h7F;
      exp_dp   <= on4 ? ~m_sh.dp[slot] : 1'b1;
      exp_an2  <= on2 ? ~(8'd1 << slot) : 8'hFF;
      exp_seg2 <= on2 ? seg : 7'h7F;
      exp_dp2  <= on2 ? ~m_sh.dp[slot] : 1'b1;
      exp_fd   <= eof;
      if (load && eof) begin
        m_sh <= f_in; m_pend_vld <= 1'b0;
      end else if (eof && m_pend_vld) begin
        m_sh <= m_pend; m_pend_vld <= 1'b0;
      end else if (load) begin
        m_pend <= f_in; m_pend_vld <= 1'b1;
      end
      m_t <= m_t + 1;
    end
  end

  logic [33:0] w_obs, w_exp;
  assign w_obs = {o_an, o_seg, o_dp, o_fd, o_an2, o_seg2, o_dp2, o_fd2};
  assign w_exp = {exp_an, exp_seg, exp_dp, exp_fd, exp_an2, exp_seg2, exp_dp2, exp_fd};

  function automatic frame_t rand_frame();
    frame_t f;
    f.digits   = $urandom;
    f.raw      = 56'({$urandom, $urandom});
    f.raw_mode = 8'($urandom);
    f.dp       = 8'($urandom);
    f.en       = 8'($urandom);
    f.b4       = 4'($urandom);
    f.b2       = 2'($urandom);
    return f;
  endfunction

  function automatic frame_t hex_frame();
    frame_t f;
    f          = rand_frame();
    f.raw_mode = 8'h00;
    f.en       = 8'hFF;
    f.b4       = 4'hF;
    return f;
  endfunction

  task automatic drive(input frame_t f);
    digits = f.digits; raw = f.raw; raw_mode = f.raw_mode; dp = f.dp; en = f.en;
    b4 = f.b4; b2 = f.b2; load = 1'b1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); load = 1'b0;
      checks++;
      if (w_obs !== w_exp) begin
        errors++;
        if (errors <= 25) $display("FAIL %s model: got %h expected %h t=%0t", tag, w_obs, w_exp, $time);
      end
    end
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk); load = 1'b0; n++;
      checks++;
      if (w_obs !== w_exp) begin
        errors++;
        if (errors <= 25) $display("FAIL %s model: got %h expected %h t=%0t", tag, w_obs, w_exp, $time);
      end
    end while (o_fd !== 1'b1 && n < 3 * FRAME);
    checks++;
    if (o_fd !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_done timeout: got %b expected 1 within %0d cycles", tag, o_fd, 3 * FRAME);
    end
  endtask

  task automatic test_reset(input string tag);
    idle($urandom_range(20, 150), tag);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_an, o_seg, o_dp, o_fd} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s outputs: got %h expected %h", tag, {o_an, o_seg, o_dp, o_fd}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    end
    checks++;
    if ({o_an2, o_seg2, o_dp2, o_fd2} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s dim outputs: got %h expected %h", tag, {o_an2, o_seg2, o_dp2, o_fd2}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    end
    rst = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      idle(1, tag);
      checks++;
      if (o_an !== 8'hFF || o_an2 !== 8'hFF) begin
        errors++;
        if (errors <= 25) $display("FAIL %s blank: got an=%h an2=%h expected ff", tag, o_an, o_an2);
      end
    end
  endtask

  task automatic test_hex_scan();
    frame_t f;
    f = hex_frame();
    f.digits = 32'h76543210; f.dp = 8'h00;
    idle($urandom_range(0, 60), "hex");
    drive(f);
    wait_fd("hex");
    for (int k = 0; k < FRAME; k++) begin
      idle(1, "hex");
      checks++;
      if (o_an !== ~(8'd1 << (k / SLOT)) || o_seg !== hex_tab[k / SLOT] || o_fd !== (k == FRAME - 1)) begin
        errors++;
        if (errors <= 25) $display("FAIL hex_scan k=%0d: got an=%h seg=%b fd=%b expected an=%h seg=%b fd=%b",
                                   k, o_an, o_seg, o_fd, ~(8'd1 << (k / SLOT)), hex_tab[k / SLOT], k == FRAME - 1);
      end
    end
  endtask

  task automatic test_raw_dp();
    frame_t     f;
    logic [6:0] want_seg;
    logic       want_dp;
    int         slot;
    f = hex_frame();
    f.raw[27:21] = 7'b0110110; f.raw_mode = 8'h08; f.dp = 8'h08;
    drive(f);
    wait_fd("raw");
    for (int k = 0; k < FRAME; k++) begin
      idle(1, "raw");
      slot     = k / SLOT;
      want_seg = (slot == 3) ? 7'b0110110 : hex_tab[f.digits[4*slot +: 4]];
      want_dp  = (slot != 3);
      checks++;
      if (o_seg !== want_seg || o_dp !== want_dp) begin
        errors++;
        if (errors <= 25) $display("FAIL raw_dp slot=%0d: got seg=%b dp=%b expected seg=%b dp=%b",
                                   slot, o_seg, o_dp, want_seg, want_dp);
      end
    end
  endtask

  task automatic test_dimming();
    int     levels [3] = '{1, 0, 3};
    int     lit [8];
    frame_t f;
    for (int i = 0; i < 3; i++) begin
      f = hex_frame();
      f.b2 = 2'(levels[i]);
      f.b4 = 4'($urandom);
      drive(f);
      wait_fd("dim");
      for (int s = 0; s < N; s++) lit[s] = 0;
      for (int k = 0; k < FRAME; k++) begin
        idle(1, "dim");
        if (o_an2 !== 8'hFF) lit[k / SLOT]++;
      end
      for (int s = 0; s < N; s++) begin
        checks++;
        if (lit[s] != (levels[i] + 1) * 4) begin
          errors++;
          $display("FAIL dim b=%0d slot=%0d: got %0d lit cycles expected %0d", levels[i], s, lit[s], (levels[i] + 1) * 4);
        end
      end
    end
  endtask

  task automatic test_double_buffer();
    frame_t fr [6];
    int     load_k [5][2] = '{'{40, -1}, '{10, 70}, '{20, 126}, '{-1, -1}, '{-1, -1}};
    int     load_f [5][2] = '{'{1, 0}, '{2, 3}, '{4, 5}, '{0, 0}, '{0, 0}};
    int     show_f [5]    = '{0, 1, 3, 5, 5};
    logic [6:0] want;
    for (int i = 0; i < 6; i++) begin
      fr[i] = hex_frame();
      fr[i].digits[3:0] = 4'(i + 1);
    end
    drive(fr[0]);
    wait_fd("dbuf");
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < FRAME; k++) begin
        idle(1, "dbuf");
        want = hex_tab[fr[show_f[p]].digits[4*(k / SLOT) +: 4]];
        checks++;
        if (o_seg !== want || o_fd !== (k == FRAME - 1)) begin
          errors++;
          if (errors <= 25) $display("FAIL dbuf phase=%0d k=%0d: got seg=%b fd=%b expected seg=%b fd=%b",
                                     p, k, o_seg, o_fd, want, k == FRAME - 1);
        end
        for (int j = 0; j < 2; j++)
          if (load_k[p][j] == k) drive(fr[load_f[p][j]]);
      end
    end
  endtask

  task automatic test_disable();
    frame_t     f;
    logic [7:0] want;
    f = hex_frame();
    f.en = 8'b1111_0111;
    drive(f);
    wait_fd("disable");
    for (int k = 0; k < FRAME; k++) begin
      idle(1, "disable");
      want = (k / SLOT == 3) ? 8'hFF : ~(8'd1 << (k / SLOT));
      checks++;
      if (o_an !== want) begin
        errors++;
        if (errors <= 25) $display("FAIL disable k=%0d: got an=%h expected %h", k, o_an, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++) begin
      idle($urandom_range(0, 150), "b2b");
      drive(rand_frame());
      if ($urandom_range(0, 1) == 1) begin
        idle(1, "b2b");
        drive(rand_frame());
      end
    end
    idle(2 * FRAME, "b2b");
  endtask

  initial begin
    test_reset("reset_initial");
    test_hex_scan();
    test_raw_dp();
    test_dimming();
    test_double_buffer();
    test_disable();
    test_back_to_back();
    test_reset("reset_midframe");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
